// File: rtl/key_conditioner.sv
// key_conditioner
//   Multi-channel front end for raw push-button / switch inputs. Each key is
//   passed through a 2-flop synchroniser, a counter-based debouncer, a
//   registered edge detector and an optional typematic auto-repeat FSM.
//   At most one press or repeat event is produced per key per clock.
//
// Parameters
//   N_KEYS       number of independent key channels
//   DB_CYCLES    consecutive stable synchronised samples needed to accept a change
//   REPEAT_DELAY cycles from a press pulse to the first repeat pulse
//   REPEAT_RATE  cycles between subsequent repeat pulses
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   key_in       raw asynchronous key levels, 1 = pressed
//   repeat_en    per-key auto-repeat enable (register-driven, not synchronised)
//   key_level    debounced key state
//   key_press    1-cycle pulse on accepted 0->1
//   key_release  1-cycle pulse on accepted 1->0
//   key_repeat   1-cycle auto-repeat pulse
//   any_press    OR of key_press, aligned with key_press
module key_conditioner #(
  parameter int N_KEYS       = 4,
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_press
);

  // Debounce counter holds 0 .. DB_CYCLES-1; repeat counter holds
  // 0 .. max(REPEAT_DELAY, REPEAT_RATE)-1.
  localparam int DW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RATE  = 2'd2;

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] lvl_p2;
  logic [N_KEYS-1:0] press_cond;
  logic [N_KEYS-1:0] release_cond;

  // The internal debounced level leads key_level by one cycle, so comparing
  // the two gives the edge one cycle ahead and lets the pulse be registered
  // into the same cycle key_level shows the new value.
  assign press_cond   = lvl_p2 & ~key_level;
  assign release_cond = ~lvl_p2 & key_level;

  // ---- stage p0/p1: synchroniser; output stage: level and edge pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_press   <= 1'b0;
    end else begin
      sync_p0     <= key_in;
      sync_p1     <= sync_p0;
      key_level   <= lvl_p2;
      key_press   <= press_cond;
      key_release <= release_cond;
      any_press   <= |press_cond;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [1:0]    state;
    logic          lvl;
    logic          rep;

    assign lvl_p2[k]     = lvl;
    assign key_repeat[k] = rep;

    // ---- stage p2: debounce, a change is accepted after DB_CYCLES
    // consecutive samples that disagree with the current level ----
    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt <= '0;
        lvl  <= 1'b0;
      end else if (sync_p1[k] == lvl) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        lvl  <= sync_p1[k];
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end

    // ---- output stage: auto-repeat FSM ----
    // Leaving DELAY/RATE is checked before the due test, so a release
    // accepted in the cycle a repeat is due suppresses that repeat.
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
        rcnt  <= '0;
        rep   <= 1'b0;
      end else begin
        rep <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (press_cond[k] && repeat_en[k]) begin
              state <= ST_DELAY;
              rcnt  <= '0;
            end
          end
          ST_DELAY, ST_RATE: begin
            if (!lvl || !repeat_en[k]) begin
              state <= ST_IDLE;
              rcnt  <= '0;
            end else if (rcnt == ((state == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
              rep   <= 1'b1;
              rcnt  <= '0;
              state <= ST_RATE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Drives key_conditioner (N_KEYS=4, DB_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_RATE=3) with directed scenarios followed by randomized bouncing
//   keys, enable changes and occasional resets. A reference model pushes
//   the expected outputs of every clock edge into a queue; a monitor pops
//   and compares on the falling edge.
module tb_key_conditioner;
  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int MAXC = 4000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] repeat_en;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_repeat;
  logic         any_press;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .any_press(any_press)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic         any;
  } exp_t;

  exp_t exp_q[$];

  // Per-edge history: inputs sampled at edge t, model level after edge t.
  logic [N-1:0] r_h   [MAXC];
  logic [N-1:0] en_h  [MAXC];
  logic         rst_h [MAXC];
  logic [N-1:0] lvl_h [MAXC];
  logic [N-1:0] out_h [MAXC];

  int last_rst = 0;
  int last_evt [N];
  bit armed    [N];
  int ptime    [N];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_press_exp = 0, n_press_dut = 0, n_rep_exp = 0, n_rep_dut = 0;

  // Synchronised sample seen by the debouncer at edge e: the raw level two
  // edges earlier, or 0 while the synchroniser is still flushing a reset.
  function automatic logic s2_of(int e, int k);
    if (e - 2 > last_rst) return r_h[e-2][k];
    return 1'b0;
  endfunction

  function automatic exp_t model_step(int t);
    exp_t x;
    logic cur, shown;
    bit   ok;
    int   d;
    x = '0;
    if (rst_h[t]) begin
      last_rst = t;
      lvl_h[t] = '0;
      out_h[t] = '0;
      for (int k = 0; k < N; k++) begin
        last_evt[k] = t;
        armed[k]    = 1'b0;
      end
      return x;
    end
    for (int k = 0; k < N; k++) begin
      cur   = lvl_h[t-1][k];
      shown = out_h[t-1][k];
      x.lvl[k] = cur;
      x.prs[k] = cur & ~shown;
      x.rel[k] = ~cur & shown;
      // Repeats fall at press+RD, press+RD+RR, ... while the key stays held
      // and enabled on every edge since the press.
      if (armed[k]) begin
        if (!cur || !en_h[t][k]) armed[k] = 1'b0;
        else begin
          d = t - ptime[k];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) x.rpt[k] = 1'b1;
        end
      end
      if (x.prs[k] && en_h[t][k]) begin
        armed[k] = 1'b1;
        ptime[k] = t;
      end
      // Level flips once DB consecutive samples since the last flip/reset
      // all disagree with it.
      lvl_h[t][k] = cur;
      if (t - last_evt[k] >= DB) begin
        ok = 1'b1;
        for (int j = 0; j < DB; j++) if (s2_of(t - j, k) == cur) ok = 1'b0;
        if (ok) begin
          lvl_h[t][k] = ~cur;
          last_evt[k] = t;
        end
      end
    end
    x.any    = |x.prs;
    out_h[t] = x.lvl;
    return x;
  endfunction

  task automatic drive(input logic [N-1:0] kin, input logic [N-1:0] en, input logic r);
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    key_in    = kin;
    repeat_en = en;
    rst       = r;
    r_h[cyc]   = kin;
    en_h[cyc]  = en;
    rst_h[cyc] = r;
    exp_q.push_back(model_step(cyc));
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic hold(input logic [N-1:0] kin, input logic [N-1:0] en, input int n);
    for (int i = 0; i < n; i++) drive(kin, en, 1'b0);
  endtask

  task automatic chk(input string nm, input int c, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%b required=%b", nm, c, act, req);
    end
  endtask

  // Monitor: one expected record per clock edge.
  initial begin : monitor
    exp_t e;
    int   mc;
    mc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("key_level",   mc, key_level,   e.lvl);
        chk("key_press",   mc, key_press,   e.prs);
        chk("key_release", mc, key_release, e.rel);
        chk("key_repeat",  mc, key_repeat,  e.rpt);
        chk("any_press",   mc, {{(N-1){1'b0}}, any_press}, {{(N-1){1'b0}}, e.any});
        n_press_exp += $countones(e.prs);
        n_rep_exp   += $countones(e.rpt);
        n_press_dut += $countones(key_press);
        n_rep_dut   += $countones(key_repeat);
        mc++;
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] kin, en, tgt;
    logic [7:0]   pat;
    int           bounce [N];
    key_in = '0; repeat_en = '0; rst = 1'b1;

    // Reset and steady low
    for (int i = 0; i < 3; i++) drive('0, '0, 1'b1);
    hold(4'b0000, 4'b0100, 10);

    // Clean press on key 0
    hold(4'b0001, 4'b0100, 15);
    hold(4'b0000, 4'b0100, 12);

    // Bounce rejection on key 1, then a stable press
    pat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) drive({2'b00, pat[i], 1'b0}, 4'b0100, 1'b0);
    hold(4'b0010, 4'b0100, 12);
    hold(4'b0000, 4'b0100, 12);

    // Auto-repeat on key 2
    hold(4'b0100, 4'b0100, 45);
    hold(4'b0000, 4'b0100, 12);

    // Repeat gating on key 3: enable raised mid-hold, then a new press
    hold(4'b1000, 4'b0100, 30);
    hold(4'b1000, 4'b1100, 30);
    hold(4'b0000, 4'b1100, 12);
    hold(4'b1000, 4'b1100, 30);
    hold(4'b0000, 4'b1100, 12);

    // Reset mid-repeat with key 0 still held
    hold(4'b0001, 4'b0001, 40);
    drive(4'b0001, 4'b0001, 1'b1);
    hold(4'b0001, 4'b0001, 40);
    hold(4'b0000, 4'b0001, 12);

    // Randomized bouncing keys, enable toggles and occasional resets
    tgt = '0;
    en  = '1;
    for (int k = 0; k < N; k++) bounce[k] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < N; k++) begin
        if (bounce[k] > 0) begin
          kin[k] = 1'($urandom_range(0, 1));
          bounce[k]--;
        end else begin
          if ($urandom_range(0, 39) == 0) begin
            tgt[k]    = ~tgt[k];
            bounce[k] = int'($urandom_range(0, 5));
          end
          kin[k] = tgt[k];
        end
        if (en[k] && $urandom_range(0, 199) == 0) en[k] = 1'b0;
        else if (!en[k] && $urandom_range(0, 29) == 0) en[k] = 1'b1;
      end
      drive(kin, en, ($urandom_range(0, 599) == 0));
    end
    hold(4'b0000, 4'b1111, 12);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (n_press_dut != n_press_exp) begin
      errors++;
      $display("FAIL press_total actual=%0d required=%0d", n_press_dut, n_press_exp);
    end
    checks++;
    if (n_rep_dut != n_rep_exp) begin
      errors++;
      $display("FAIL repeat_total actual=%0d required=%0d", n_rep_dut, n_rep_exp);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
